spm_seq_ctrl: RTL
=================

// Module: spm_seq_ctrl
// PURPOSE
//  Sequencer for the N-bit serial-parallel multiplier. On a start-button edge it
//  captures two signed operands from the switches and loads their magnitudes into
//  the multiplier. It then runs 2N shift cycles, hands the product to the BCD
//  converter, waits for it to finish and flags the result valid.
//  It sits between the Basys3 buttons/switches and the multiplier, the BCD converter
//  and view-mode datapath; it pulses view_rst so the display returns to mode 00.
// PARAMETERS
//  N        8        operand width (bits); product magnitude is 2N bits
//  TIMEOUT  1024     max cycles in WAIT_BCD before err is raised
// PORTS
//  clk            in   1    100 MHz clock
//  rst            in   1    synchronous reset, active-high
//  btn_start      in   1    raw start button, asynchronous (BTNL)
//  sw_a           in   N    operand A, two's complement
//  sw_b           in   N    operand B, two's complement
//  mult_load      out  1    1-cycle pulse: multiplier loads mult_a/mult_b, clears accumulator
//  mult_shift_en  out  1    multiplier advances one bit per cycle while high
//  mult_a         out  N    |A| (unsigned), held stable from LOAD until next capture
//  mult_b         out  N    |B| (unsigned), held stable likewise
//  bcd_start      out  1    1-cycle pulse: BCD converter samples the product
//  bcd_done       in   1    converter completion; level or pulse, sampled every cycle
//  neg            out  1    product sign = sw_a[N-1] ^ sw_b[N-1], forced 0 if either operand is 0
//  busy           out  1    high in LOAD, SHIFT, CONV, WAIT_BCD
//  result_valid   out  1    high in DONE
//  view_rst       out  1    1-cycle pulse on entry to DONE
//  err            out  1    sticky timeout flag, cleared only by rst or next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt 0, sync/edge flops 0. A reset mid-operation
//   aborts: next cycle all outputs are 0 and the FSM is in IDLE.
//  Start: btn_start goes through a 2-FF synchronizer, then rising-edge detect ->
//   start_rise (1 cycle). Accepted only in IDLE or DONE; ignored while busy, not queued.
//  Capture (cycle of accepted start_rise): mult_a<=|sw_a|, mult_b<=|sw_b|, neg computed,
//   err<=0. |x| = x[N-1] ? -x : x, taken in N-bit unsigned; -2^(N-1) gives 2^(N-1) (0x80).
//  FSM (one transition per clk):
//   IDLE     : start_rise -> LOAD
//   LOAD     : mult_load=1, cnt<=0 -> SHIFT
//   SHIFT    : mult_shift_en=1, cnt++; at cnt==2N-1 -> CONV (exactly 2N shift cycles)
//   CONV     : bcd_start=1 -> WAIT_BCD; tmo<=0
//   WAIT_BCD : bcd_done -> DONE; else tmo++; tmo==TIMEOUT-1 -> IDLE, err<=1
//   DONE     : result_valid=1; view_rst=1 on first cycle only; start_rise -> LOAD
//  Latency: start_rise at cycle k -> mult_load at k+1, shift k+2..k+2N+1,
//   bcd_start at k+2N+2. result_valid rises 1 cycle after bcd_done is sampled.
//  bcd_done in any state other than WAIT_BCD is ignored (it may be a stale level).
//  All outputs are registered and glitch-free; cnt width = $clog2(2N), tmo = $clog2(TIMEOUT).
//  Simultaneous rst and start_rise: rst wins.
// STRUCTURE
//  Shared package spm_pkg: state encoding localparams (IDLE..DONE, 3 bits), default N.
//  One sub-module: btn_edge_sync (2-FF sync + rising-edge pulse). Reused later for BTNC/BTNR.
//  The FSM, counters and operand registers stay in this module.
// TESTING
//  1. Capture: A=5, B=3 and start pressed -> mult_a=5, mult_b=3, neg=0; mult_load 1 cycle,
//     then exactly 16 mult_shift_en cycles, then one bcd_start.
//  2. Signs: A=-128 (0x80), B=-1 (0xFF) -> mult_a=0x80, mult_b=0x01, neg=0;
//     A=-7, B=0 -> neg=0.
//  3. Busy press: second start edge during SHIFT -> ignored; shift count stays 16 and
//     there is no second mult_load.
//  4. Completion: bcd_done pulsed 10 cycles after bcd_start -> result_valid next cycle,
//     view_rst exactly 1 cycle; a press in DONE -> LOAD directly, result_valid drops.
//  5. Timeout: bcd_done held 0 -> after TIMEOUT cycles err=1, state IDLE, busy=0; the next
//     start clears err.
//  6. Reset mid-SHIFT (cnt=7): rst 1 cycle -> all outputs 0, IDLE; a stale bcd_done is ignored.

Source files
------------

// File: rtl/spm_seq_ctrl_pkg.sv
// Shared definitions for the serial-parallel multiplier sequencer:
// default sizing and the 3-bit state encoding.
package spm_seq_ctrl_pkg;

   localparam int SPM_N_DEF       = 8;
   localparam int SPM_TIMEOUT_DEF = 1024;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_SHIFT    = 3'd2;
   localparam logic [2:0] ST_CONV     = 3'd3;
   localparam logic [2:0] ST_WAIT_BCD = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      LOAD     = ST_LOAD,
      SHIFT    = ST_SHIFT,
      CONV     = ST_CONV,
      WAIT_BCD = ST_WAIT_BCD,
      DONE     = ST_DONE
   } spm_state_t;

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Signals between the sequencer and the board I/O, multiplier and BCD converter.
// master = sequencer side, slave = surrounding datapath / board side.
interface spm_seq_ctrl_if #(parameter int N = spm_seq_ctrl_pkg::SPM_N_DEF);
   logic         btn_start;
   logic [N-1:0] sw_a;
   logic [N-1:0] sw_b;
   logic         mult_load;
   logic         mult_shift_en;
   logic [N-1:0] mult_a;
   logic [N-1:0] mult_b;
   logic         bcd_start;
   logic         bcd_done;
   logic         neg;
   logic         busy;
   logic         result_valid;
   logic         view_rst;
   logic         err;

   modport master (
      input  btn_start, sw_a, sw_b, bcd_done,
      output mult_load, mult_shift_en, mult_a, mult_b, bcd_start,
             neg, busy, result_valid, view_rst, err
   );

   modport slave (
      output btn_start, sw_a, sw_b, bcd_done,
      input  mult_load, mult_shift_en, mult_a, mult_b, bcd_start,
             neg, busy, result_valid, view_rst, err
   );
endinterface

// File: rtl/spm_seq_ctrl_btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// single-cycle rising-edge pulse.
module btn_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic rise_o
);
   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the N-bit serial-parallel multiplier: captures signed operands
// on a start press, runs 2N shift cycles, then hands the product to the BCD converter.
//
// state    | meaning
// IDLE     | waiting for a start press
// LOAD     | multiplier loads magnitudes, clears accumulator
// SHIFT    | 2N shift cycles
// CONV     | one-cycle kick of the BCD converter
// WAIT_BCD | waiting for bcd_done, bounded by TIMEOUT
// DONE     | result valid, new press restarts directly
module spm_seq_ctrl
   import spm_seq_ctrl_pkg::*;
#(
   parameter int N       = SPM_N_DEF,
   parameter int TIMEOUT = SPM_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   spm_seq_ctrl_if.master  bus
);
   localparam int CW = $clog2(2*N);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(2*N-1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT-1);

   spm_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   logic          capture;
   logic          start_rise;

   logic          load_q, shift_q, bcd_start_q, busy_q, valid_q, view_rst_q, neg_q;
   logic [N-1:0]  mult_a_q, mult_b_q;
   logic [N-1:0]  abs_a, abs_b;
   logic          neg_d;

   btn_edge_sync u_start_sync (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (bus.btn_start),
      .rise_o (start_rise)
   );

   // Negating -2^(N-1) wraps back to itself, which is the correct unsigned magnitude.
   assign abs_a = bus.sw_a[N-1] ? ('0 - bus.sw_a) : bus.sw_a;
   assign abs_b = bus.sw_b[N-1] ? ('0 - bus.sw_b) : bus.sw_b;
   assign neg_d = (bus.sw_a[N-1] ^ bus.sw_b[N-1]) & (|bus.sw_a) & (|bus.sw_b);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      capture = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_rise) begin
               state_d = LOAD;
               capture = 1'b1;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = CONV;
         end
         CONV: begin
            tmo_d   = '0;
            state_d = WAIT_BCD;
         end
         WAIT_BCD: begin
            if (bus.bcd_done) begin
               state_d = DONE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (capture) err_d = 1'b0;
   end

   // Outputs are decoded from the next state so each one comes straight off a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         load_q      <= 1'b0;
         shift_q     <= 1'b0;
         bcd_start_q <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         view_rst_q  <= 1'b0;
         neg_q       <= 1'b0;
         mult_a_q    <= '0;
         mult_b_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         load_q      <= (state_d == LOAD);
         shift_q     <= (state_d == SHIFT);
         bcd_start_q <= (state_d == CONV);
         busy_q      <= (state_d inside {LOAD, SHIFT, CONV, WAIT_BCD});
         valid_q     <= (state_d == DONE);
         view_rst_q  <= (state_d == DONE) && (state_q != DONE);
         if (capture) begin
            mult_a_q <= abs_a;
            mult_b_q <= abs_b;
            neg_q    <= neg_d;
         end
      end
   end

   assign bus.mult_load     = load_q;
   assign bus.mult_shift_en = shift_q;
   assign bus.bcd_start     = bcd_start_q;
   assign bus.busy          = busy_q;
   assign bus.result_valid  = valid_q;
   assign bus.view_rst      = view_rst_q;
   assign bus.neg           = neg_q;
   assign bus.err           = err_q;
   assign bus.mult_a        = mult_a_q;
   assign bus.mult_b        = mult_b_q;
endmodule
